sram_rd_streamer: RTL

Read-side sequencer for the single-port `sram` buffer. On a start command it issues a burst of `len` consecutive reads from `base_addr` and absorbs the SRAM's one-cycle read latency in a small output FIFO. It presents the words as a valid/ready stream to the downstream compute stage. The buffer's write port is owned by another stage, so this block only issues reads.

---
 rtl/sram_rd_streamer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: reads a burst of consecutive words from a single-port SRAM
// and streams them out over valid/ready. A small FIFO hides the SRAM's
// one-cycle read latency, and reads are only issued while FIFO space is free.
module sram_rd_streamer #(
  parameter int unsigned WORDWIDTH  = 32,
  parameter int unsigned WORDDEPTH  = 2048,
  parameter int unsigned ADDRWIDTH  = $clog2(WORDDEPTH),
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [ADDRWIDTH:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_cen,
  output logic                 sram_wen,
  output logic [ADDRWIDTH-1:0] sram_addr,
  input  logic [WORDWIDTH-1:0] sram_dout,
  output logic                 out_valid,
  output logic [WORDWIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CRW = CW + 1;
  localparam int unsigned LW  = ADDRWIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LW-1:0]        len_q;
  logic [LW-1:0]        issued;
  logic [LW-1:0]        accepted;
  logic [ADDRWIDTH-1:0] cur_addr;
  logic [ADDRWIDTH-1:0] last_addr;
  logic                 inflight;
  logic [CW-1:0]        count;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [WORDWIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic start_acc;
  logic issue;
  logic push;
  logic pop;
  logic credit_ok;
  logic last_hs;

  // Stream-side decode of the FIFO head
  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (accepted == (len_q - LW'(1)));
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign last_hs   = pop & out_last;
  assign start_acc = (state == S_IDLE) & start;

  // A read may only be issued if its word is guaranteed a FIFO slot on arrival;
  // a pop in this cycle frees a slot immediately.
  assign credit_ok = (CRW'(count) + CRW'(inflight)) < (CRW'(FIFO_DEPTH) + CRW'(pop));
  assign issue     = (state == S_RUN) && (issued < len_q) && credit_ok;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = last_addr;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_hs) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (issue) begin
      sram_cen  = 1'b0;
      sram_addr = cur_addr;
    end
  end

  // Burst bookkeeping: address, issue/accept counters, read-latency flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      issued    <= '0;
      accepted  <= '0;
      cur_addr  <= '0;
      last_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (start_acc) begin
        len_q    <= len;
        cur_addr <= base_addr;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) begin
          issued    <= issued + LW'(1);
          last_addr <= cur_addr;
          cur_addr  <= (cur_addr == ADDRWIDTH'(WORDDEPTH - 1)) ? '0 : cur_addr + ADDRWIDTH'(1);
        end
        if (pop) accepted <= accepted + LW'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage captures the SRAM word the cycle after its read was issued
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_dout;
  end

endmodule
